// File: rtl/fft_pkg.sv
// Shared FFT definitions: frame size, sample width default and the bit-reversal helper
// used by the FFT datapath and the output reorder buffer.
package fft_pkg;

    localparam int FFT_N          = 16;
    localparam int LOG2N          = $clog2(FFT_N);
    localparam int DEFAULT_DATA_W = 16;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
        logic [LOG2N-1:0] rev;
        rev = '0;
        for (int i = 0; i < LOG2N; i++) begin
            rev[i] = idx[LOG2N-1-i];
        end
        return rev;
    endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// Stream bundle around the reorder buffer: bit-reversed input stream and
// natural-order output stream with index/last side-band.
interface fft_bitrev_reorder_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_re;
    logic [DATA_W-1:0] in_im;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_re;
    logic [DATA_W-1:0] out_im;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;

    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_idx, out_last
    );

endinterface

// File: rtl/bit_reversal.sv
// Combinational index bit-reversal for an N-point frame (mirrors fft_pkg::bitrev
// for any power-of-two N).
module bit_reversal #(
    parameter int N = 16
) (
    input  logic [$clog2(N)-1:0] idx_i,
    output logic [$clog2(N)-1:0] rev_o
);
    localparam int W = $clog2(N);

    // Mirror the index bits
    always_comb begin
        rev_o = '0;
        for (int i = 0; i < W; i++) begin
            rev_o[i] = idx_i[W-1-i];
        end
    end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong frame reorder buffer: writes each bit-reversed frame into one bank at
// bitrev(wc) and replays the other bank in natural order, one sample per cycle.
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int N      = FFT_N,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fft_bitrev_reorder_if.slave  bus
);
    localparam int                IDX_W    = $clog2(N);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);

    logic                wb_q, wb_d;
    logic                rb_q, rb_d;
    logic [IDX_W-1:0]    wc_q, wc_d;
    logic [IDX_W-1:0]    rc_q, rc_d;
    logic [1:0]          full_q, full_d;
    logic [IDX_W-1:0]    wr_addr;
    logic                wr_en;
    logic                rd_en;
    logic [2*DATA_W-1:0] rd_word;
    logic [2*DATA_W-1:0] mem_q [2][N];

    bit_reversal #(.N(N)) u_bitrev (
        .idx_i (wc_q),
        .rev_o (wr_addr)
    );

    // Handshakes depend only on the full flags, never on in_valid/out_ready
    assign bus.in_ready  = ~full_q[wb_q];
    assign bus.out_valid = full_q[rb_q];
    assign wr_en         = bus.in_valid & ~full_q[wb_q];
    assign rd_en         = full_q[rb_q] & bus.out_ready;

    assign rd_word      = mem_q[rb_q][rc_q];
    assign bus.out_re   = rd_word[2*DATA_W-1:DATA_W];
    assign bus.out_im   = rd_word[DATA_W-1:0];
    assign bus.out_idx  = rc_q;
    assign bus.out_last = (rc_q == LAST_IDX);

    // Pointer, counter and full-flag next state; a bank can only be set while
    // it is the write bank and cleared while it is the read bank, so both
    // frame-end events may land in the same cycle.
    always_comb begin
        wc_d   = wc_q;
        wb_d   = wb_q;
        rc_d   = rc_q;
        rb_d   = rb_q;
        full_d = full_q;
        if (wr_en) begin
            wc_d = wc_q + IDX_W'(1);
            if (wc_q == LAST_IDX) begin
                full_d[wb_q] = 1'b1;
                wb_d         = ~wb_q;
            end else begin
                wb_d = wb_q;
            end
        end else begin
            wc_d = wc_q;
        end
        if (rd_en) begin
            rc_d = rc_q + IDX_W'(1);
            if (rc_q == LAST_IDX) begin
                full_d[rb_q] = 1'b0;
                rb_d         = ~rb_q;
            end else begin
                rb_d = rb_q;
            end
        end else begin
            rc_d = rc_q;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q   <= 1'b0;
            rb_q   <= 1'b0;
            wc_q   <= '0;
            rc_q   <= '0;
            full_q <= 2'b00;
        end else begin
            wb_q   <= wb_d;
            rb_q   <= rb_d;
            wc_q   <= wc_d;
            rc_q   <= rc_d;
            full_q <= full_d;
        end
    end

    // Sample storage; cleared on reset so idle outputs read as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < N; i++) begin
                    mem_q[b][i] <= '0;
                end
            end
        end else if (wr_en) begin
            mem_q[wb_q][wr_addr] <= {bus.in_re, bus.in_im};
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench for fft_bitrev_reorder: frames are pushed as natural-order
// expectations when issued; a negedge monitor pops and compares every output beat.
module tb_fft_bitrev_reorder;
    import fft_pkg::*;

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t exp_q[$];
    bit   rand_mode;
    bit   stream_mon;
    bit   stall_mon;
    int   drop_cnt;
    int   stall_bad;

    fft_bitrev_reorder_if #(.DATA_W(16), .IDX_W(4)) bus ();

    fft_bitrev_reorder #(.N(16), .DATA_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Output monitor / scoreboard consumer
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {28'd0, bus.out_idx}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_re",   {16'd0, bus.out_re},  {16'd0, e.re});
                chk("out_im",   {16'd0, bus.out_im},  {16'd0, e.im});
                chk("out_idx",  {28'd0, bus.out_idx}, {28'd0, e.idx});
                chk("out_last", {31'd0, bus.out_last}, {31'd0, e.last});
            end
        end
        if (stream_mon && bus.in_valid === 1'b1 && bus.in_ready !== 1'b1) drop_cnt++;
        if (stall_mon && bus.out_valid === 1'b1 && (bus.out_re !== 16'd0 || bus.out_idx !== 4'd0)) stall_bad++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [15:0] re, input logic [15:0] im);
        bit acc;
        int guard;
        if (rand_mode && $urandom_range(0, 1) == 1) begin
            bus.in_valid = 1'b0;
            tick();
        end
        bus.in_valid = 1'b1;
        bus.in_re    = re;
        bus.in_im    = im;
        acc          = 1'b0;
        guard        = 0;
        while (!acc) begin
            @(negedge clk);
            acc = bus.in_ready;
            tick();
            guard++;
            if (!acc && guard > 300) begin
                chk("in_accept_timeout", 32'd0, 32'd1);
                acc = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    // Issue nsend arrivals of frame f in bit-reversed order; push expectations once complete
    task automatic send_frame(input int f, input bit rnd, input int nsend, input bit lat_chk);
        logic [15:0] re_v [16];
        logic [15:0] im_v [16];
        logic [3:0]  j;
        for (int n = 0; n < 16; n++) begin
            if (rnd) begin
                re_v[n] = 16'($urandom);
                im_v[n] = 16'($urandom);
            end else begin
                re_v[n] = 16'(n + 16 * f);
                im_v[n] = 16'(16'd0 - re_v[n]);
            end
        end
        for (int k = 0; k < nsend; k++) begin
            j = bitrev(4'(k));
            if (lat_chk && k == 15) chk("valid_before_last", {31'd0, bus.out_valid}, 32'd0);
            send(re_v[j], im_v[j]);
        end
        if (lat_chk) chk("valid_after_last", {31'd0, bus.out_valid}, 32'd1);
        if (nsend == 16) begin
            for (int n = 0; n < 16; n++) begin
                exp_q.push_back('{re: re_v[n], im: im_v[n], idx: 4'(n), last: (n == 15)});
            end
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            tick();
            guard++;
        end
        chk("drain_left", exp_q.size(), 32'd0);
        tick();
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rand_mode    = 1'b0;
        stream_mon   = 1'b0;
        stall_mon    = 1'b0;
        drop_cnt     = 0;
        stall_bad    = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_re    = 16'd0;
        bus.in_im    = 16'd0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_re",    {16'd0, bus.out_re},    32'd0);
        chk("rst_out_im",    {16'd0, bus.out_im},    32'd0);
        chk("rst_out_idx",   {28'd0, bus.out_idx},   32'd0);
        chk("rst_out_last",  {31'd0, bus.out_last},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single frame with latency check
        bus.out_ready = 1'b1;
        send_frame(0, 1'b0, 16, 1'b1);
        drain();

        // Four frames back to back
        stream_mon = 1'b1;
        for (int f = 1; f <= 4; f++) begin
            send_frame(f, 1'b0, 16, 1'b0);
        end
        stream_mon = 1'b0;
        chk("b2b_contiguous_q", exp_q.size(), 32'd16);
        chk("b2b_in_ready_drops", drop_cnt, 32'd0);
        drain();

        // Backpressure: two frames stored while the sink stalls
        bus.out_ready = 1'b0;
        stall_mon     = 1'b1;
        send_frame(0, 1'b0, 16, 1'b0);
        send_frame(1, 1'b0, 16, 1'b0);
        chk("bp_in_ready_low",  {31'd0, bus.in_ready},  32'd0);
        chk("bp_out_valid",     {31'd0, bus.out_valid}, 32'd1);
        chk("bp_queued",        exp_q.size(),           32'd32);
        repeat (3) tick();
        stall_mon = 1'b0;
        chk("bp_stall_stable", stall_bad, 32'd0);
        bus.out_ready = 1'b1;
        repeat (15) tick();
        chk("bp_ready_after15", {31'd0, bus.in_ready}, 32'd0);
        tick();
        chk("bp_ready_after16", {31'd0, bus.in_ready}, 32'd1);
        drain();

        // Random stalls on both sides
        rand_mode = 1'b1;
        for (int f = 0; f < 20; f++) begin
            send_frame(f, 1'b1, 16, 1'b0);
        end
        drain();
        rand_mode     = 1'b0;
        bus.out_ready = 1'b0;
        tick();

        // Reset in the middle of the second frame
        send_frame(2, 1'b0, 16, 1'b0);
        send_frame(3, 1'b0, 7, 1'b0);
        chk("mid_full_valid", {31'd0, bus.out_valid}, 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        chk("mid_rst_out_re",    {16'd0, bus.out_re},    32'd0);
        chk("mid_rst_out_idx",   {28'd0, bus.out_idx},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        bus.out_ready = 1'b1;
        send_frame(5, 1'b0, 16, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
